mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage data-access controller sitting between the EX/MEM register and the MEM/WB register. It takes the load/store in the MEM stage, checks alignment, and runs a request/hit handshake with the data cache. It formats RISC-V byte, halfword and word loads and stores. It then holds the formatted load word stable as `dmem_out` until the MEM/WB register captures it, and drives a stall to the hazard unit while the access is outstanding.

## Interface
Parameters:
- `WORD_W`, 32, datapath width (`word_t`).

Ports:
- `CLK`  in  1  rising-edge clock.
- `nRST`  in  1  asynchronous, active-low reset.
- `MemRead_MEM`  in  1  load in MEM stage.
- `MemWrite_MEM`  in  1  store in MEM stage.
- `funct3_MEM`  in  3  access size/sign:
  - 000 lb/sb, 001 lh/sh, 010 lw/sw.
  - 100 lbu, 101 lhu.
- `alu_out_MEM`  in  32  effective byte address.
- `store_data_MEM`  in  32  rs2 value.
- `mem_advance`  in  1  MEM/WB register captures this cycle (`pipeline_ctrl` advance).
- `dhit`  in  1  cache completion for the current request.
- `dmemload`  in  32  cache read word; valid when `dhit`.
- `dmemREN`  out  1  cache read request.
- `dmemWEN`  out  1  cache write request.
- `dmemaddr`  out  32  word-aligned address (`{addr[31:2],2'b00}`).
- `dmemstore`  out  32  store word, lane-positioned.
- `dmem_be`  out  4  store byte enables.
- `dmem_out`  out  32  formatted load result, to MEM/WB.
- `mem_busy`  out  1  stall request to hazard unit.
- `misaligned`  out  1  one-cycle alignment/illegal-access flag.

## Operation
Access decode:
- `req = MemRead_MEM | MemWrite_MEM`.
- Illegal when:
  - both `MemRead_MEM` and `MemWrite_MEM` are set;
  - `funct3` is 011, 110 or 111;
  - a halfword access has `addr[0]=1`;
  - a word access has `addr[1:0]≠0`.

Three-state FSM:
- IDLE:
  - Legal `req` → REQ, latching address, size, sign, direction and store data into internal registers.
  - Illegal `req` → stay IDLE; `misaligned=1` that cycle; no cache request; `dmem_out=0`.
  - No `req` → stay IDLE.
- REQ:
  - `dmemREN`/`dmemWEN` are held from the latched registers.
  - `dhit=0` → stay REQ.
  - `dhit=1` → DONE. For loads, `dmem_out` is loaded with the formatted `dmemload`.
- DONE:
  - No cache request.
  - `dmem_out` is held.
  - `mem_advance=1` → IDLE.

Stall and outputs:
- `mem_busy = (IDLE & legal req) | REQ`. It is low in DONE and low for illegal accesses.
- `dmemREN`, `dmemWEN`, `dmem_be` and `dmemstore` are zero outside REQ.

Load formatting (latched `addr[1:0]`):
- Byte: lane `addr[1:0]`.
- Halfword: lane `addr[1]`.
- Sign-extended for lb/lh, zero-extended for lbu/lhu; lw passes the word through.

Store formatting:
- sb: byte replicated ×4, `be=1<<addr[1:0]`.
- sh: halfword replicated ×2, `be=addr[1]?1100:0011`.
- sw: `be=1111`.

Stores leave `dmem_out` unchanged.

## Timing
- Reset (async, `nRST=0`): state IDLE; `dmem_out=0`; all latched registers 0; all outputs 0. Reset asserted mid-REQ abandons the request immediately (`dmemREN`/`dmemWEN` drop asynchronously).
- Cycle flow:
  - Legal access presented in cycle N (IDLE): `mem_busy=1` in N; request outputs asserted from N+1.
  - With `dhit` in cycle N+k (k≥1), DONE and valid `dmem_out` follow from N+k+1; `mem_busy=0` from N+k+1.
  - Minimum total latency is 2 cycles.
- `dhit` in IDLE or DONE is ignored.
- `mem_advance` in IDLE or REQ has no effect. The hazard unit must not advance while `mem_busy=1`.
- If `mem_advance` stays 0 in DONE (downstream stall), DONE holds indefinitely with `dmem_out` stable.
- A new access can be accepted the cycle after leaving DONE. Back-to-back legal accesses are therefore separated by one IDLE cycle.
- Inputs are sampled only in IDLE. Changes during REQ or DONE do not alter the request in flight.

## Test plan
- lw at 0x0000_0040, `dhit` 2 cycles after REQ entry, `dmemload=0xDEADBEEF` → `dmemaddr=0x40`, `dmemREN` high for 2 cycles, `dmem_out=0xDEADBEEF` on the DONE cycle, `mem_busy` high for 3 cycles total.
- lb at 0x43, `dmemload=0x80FF_0000` → `dmem_out=0xFFFF_FF80`; lbu at the same address → `0x0000_0080`; lhu at 0x42 → `0x0000_80FF`.
- sh at 0x46, `store_data=0x1234_ABCD`, `dhit` immediate → `dmemaddr=0x44`, `dmemstore=0xABCD_ABCD`, `dmem_be=1100`, `dmemWEN` high exactly 1 cycle, `dmem_out` unchanged.
- lw at 0x42 → `misaligned` pulse 1 cycle, no `dmemREN`, `mem_busy=0`, `dmem_out=0`; same for `MemRead_MEM=MemWrite_MEM=1`.
- Load completes, `mem_advance` held low 3 cycles → state stays DONE, `dmem_out` stable, no new request despite changed inputs; `mem_advance=1` → IDLE next cycle.
- `nRST` pulsed low mid-REQ → `dmemREN` drops without waiting for a clock, `dmem_out=0`, and the next access after release runs normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: checks alignment, runs the dcache req/hit handshake and formats sub-word data.
// Latency: >=2 cycles (accept in IDLE, hit in REQ, result held in DONE until MEM/WB captures it).
module mem_access_unit #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_MEM,
    input  logic [2:0]        funct3_MEM,
    input  logic [WORD_W-1:0] alu_out_MEM,
    input  logic [WORD_W-1:0] store_data_MEM,
    input  logic              mem_advance,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [3:0]        dmem_be,
    output logic [WORD_W-1:0] dmem_out,
    output logic              mem_busy,
    output logic              misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [WORD_W-1:0] store_q, store_d;
    logic [3:0]        be_q, be_d;
    logic [WORD_W-1:0] dmem_out_q, dmem_out_d;

    logic              req, illegal, accept, reject;
    logic [WORD_W-1:0] store_fmt;
    logic [3:0]        be_fmt;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [WORD_W-1:0] load_fmt;

    always_comb begin
        req     = MemRead_MEM | MemWrite_MEM;
        illegal = (MemRead_MEM & MemWrite_MEM)
                | (funct3_MEM == 3'b011) | (funct3_MEM == 3'b110) | (funct3_MEM == 3'b111)
                | ((funct3_MEM[1:0] == 2'b01) & alu_out_MEM[0])
                | ((funct3_MEM[1:0] == 2'b10) & (alu_out_MEM[1:0] != 2'b00));
        accept  = (state_q == IDLE) & req & ~illegal;
        reject  = (state_q == IDLE) & req & illegal;
    end

    // Stores are lane-positioned at accept time so REQ only replays registers.
    always_comb begin
        store_fmt = store_data_MEM;
        be_fmt    = 4'b1111;
        case (funct3_MEM[1:0])
            2'b00: begin
                store_fmt = {4{store_data_MEM[7:0]}};
                be_fmt    = 4'b0001 << alu_out_MEM[1:0];
            end
            2'b01: begin
                store_fmt = {2{store_data_MEM[15:0]}};
                be_fmt    = alu_out_MEM[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = dmemload[7:0];
            2'b01:   ld_byte = dmemload[15:8];
            2'b10:   ld_byte = dmemload[23:16];
            default: ld_byte = dmemload[31:24];
        endcase
        ld_half = addr_q[1] ? dmemload[31:16] : dmemload[15:0];
        case (size_q)
            2'b00:   load_fmt = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_fmt = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: load_fmt = dmemload;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        store_d    = store_q;
        be_d       = be_q;
        dmem_out_d = dmem_out_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQ;
                    addr_d  = alu_out_MEM;
                    size_d  = funct3_MEM[1:0];
                    uns_d   = funct3_MEM[2];
                    rd_d    = MemRead_MEM;
                    wr_d    = MemWrite_MEM;
                    store_d = store_fmt;
                    be_d    = be_fmt;
                end else if (reject) begin
                    dmem_out_d = '0;
                end
            end
            REQ: begin
                if (dhit) begin
                    state_d = DONE;
                    if (rd_q) dmem_out_d = load_fmt;
                end
            end
            DONE: begin
                if (mem_advance) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            store_q    <= '0;
            be_q       <= '0;
            dmem_out_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            store_q    <= store_d;
            be_q       <= be_d;
            dmem_out_q <= dmem_out_d;
        end
    end

    // Gating with nRST keeps the input-dependent outputs quiet while held in reset.
    always_comb begin
        dmemREN    = (state_q == REQ) & rd_q;
        dmemWEN    = (state_q == REQ) & wr_q;
        dmemaddr   = {addr_q[WORD_W-1:2], 2'b00};
        dmemstore  = dmemWEN ? store_q : '0;
        dmem_be    = dmemWEN ? be_q : 4'b0000;
        dmem_out   = reject ? '0 : dmem_out_q;
        mem_busy   = nRST & (accept | (state_q == REQ));
        misaligned = nRST & reject;
    end

endmodule
